// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment scanner stepped by an async slow clock.
// One digit per slow-clock rise, a blank gap between digits, and a once-per-frame snapshot.
module seg_scan #(
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_slow,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n
);

   if (BLANK_CYC < 0 || BLANK_CYC > 255) begin : g_bad_blank
      $error("seg_scan: BLANK_CYC must be within 0..255");
   end

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

   localparam int       BL        = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
   localparam logic [7:0] BCNT_LOAD = 8'(BL);
   localparam state_e   ENTER     = (BLANK_CYC == 0) ? SHOW : BLANK;

   logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic        rdy_q, rdy_d, arm_q, arm_d;
   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  bcnt_q, bcnt_d;
   logic [15:0] snap_val_q, snap_val_d;
   logic [3:0]  snap_dp_q, snap_dp_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_n_q, dp_n_d;
   logic        tick;
   logic [15:0] hi;
   logic        lz;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      s1_d = clk_slow;
      s2_d = s1_q;
      s3_d = s2_q;
      rdy_d = 1'b1;
      // arm only after a genuine low is seen, so a level held high at release is ignored
      arm_d = arm_q | (rdy_q & ~s1_q);
      tick = s2_q & ~s3_q & arm_q;

      state_d = state_q;
      idx_d = idx_q;
      bcnt_d = bcnt_q;
      snap_val_d = snap_val_q;
      snap_dp_d = snap_dp_q;

      if (tick) begin
         if (state_q == IDLE || idx_q == 2'd3) begin
            snap_val_d = value;
            snap_dp_d = dp;
         end
         if (state_q != IDLE) begin
            idx_d = idx_q + 2'd1;
         end
         bcnt_d = BCNT_LOAD;
         state_d = ENTER;
      end else if (state_q == BLANK) begin
         if (bcnt_q == 8'd0) begin
            state_d = SHOW;
         end else begin
            bcnt_d = bcnt_q - 8'd1;
         end
      end

      hi = snap_val_d >> {idx_d, 2'b00};
      lz = blank_lz & (idx_d != 2'd0) & (hi == 16'd0);

      an_d = 4'hF;
      seg_d = 7'h7F;
      dp_n_d = 1'b1;
      if (state_d == SHOW) begin
         an_d = ~(4'b0001 << idx_d);
         seg_d = lz ? 7'h7F : dec7(hi[3:0]);
         dp_n_d = ~snap_dp_d[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
         rdy_q <= 1'b0;
         arm_q <= 1'b0;
         state_q <= IDLE;
         idx_q <= 2'd0;
         bcnt_q <= 8'd0;
         snap_val_q <= 16'd0;
         snap_dp_q <= 4'd0;
         an_q <= 4'hF;
         seg_q <= 7'h7F;
         dp_n_q <= 1'b1;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
         rdy_q <= rdy_d;
         arm_q <= arm_d;
         state_q <= state_d;
         idx_q <= idx_d;
         bcnt_q <= bcnt_d;
         snap_val_q <= snap_val_d;
         snap_dp_q <= snap_dp_d;
         an_q <= an_d;
         seg_q <= seg_d;
         dp_n_q <= dp_n_d;
      end
   end

   assign an = an_q;
   assign seg = seg_q;
   assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: random slow-clock and value stimulus on two blank settings,
// checked every cycle against a time-since-tick display model.
module tb_seg_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_slow = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp = 4'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an16, an0;
   logic [6:0]  seg16, seg0;
   logic        dpn16, dpn0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   seg_scan #(.BLANK_CYC(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .clk_slow(clk_slow),
      .value(value), .dp(dp), .blank_lz(blank_lz),
      .an(an16), .seg(seg16), .dp_n(dpn16)
   );

   seg_scan #(.BLANK_CYC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clk_slow(clk_slow),
      .value(value), .dp(dp), .blank_lz(blank_lz),
      .an(an0), .seg(seg0), .dp_n(dpn0)
   );

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // model: per instance, whether started, digit shown, snapshot, edge of last tick
   int          blk [2] = '{16, 0};
   bit          on [2];
   int          mi [2];
   logic [15:0] sv [2];
   logic [3:0]  sd [2];
   longint      last [2];
   longint      g = 0;
   int          rel = 0;
   bit          prev = 1'b0;
   longint      pend [$];
   int          left = 0;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got=%h expected=%h", tag, g, got, exp);
      end
   endtask

   function automatic logic [11:0] exp_disp(input int k);
      logic [3:0]  a;
      logic [6:0]  s;
      logic [15:0] h;
      if (!on[k] || (g - last[k]) < longint'(blk[k])) return 12'hFFF;
      a = 4'hF;
      a[mi[k]] = 1'b0;
      h = sv[k] >> (4 * mi[k]);
      if (blank_lz && mi[k] > 0 && h == 16'h0) s = 7'h7F;
      else s = SEG_TAB[h[3:0]];
      return {a, s, ~sd[k][mi[k]]};
   endfunction

   task automatic cyc();
      bit cur;
      bit rise;
      @(posedge clk);
      g++;
      if (!rst_n) begin
         rel = 0;
         pend.delete();
         on = '{1'b0, 1'b0};
      end else begin
         cur = clk_slow;
         rise = (rel >= 1) && !prev && cur;
         prev = cur;
         rel++;
         if (rise) pend.push_back(g + 2);
         if (pend.size() > 0 && pend[0] == g) begin
            void'(pend.pop_front());
            for (int k = 0; k < 2; k++) begin
               if (!on[k]) begin
                  on[k] = 1'b1;
                  mi[k] = 0;
                  sv[k] = value;
                  sd[k] = dp;
               end else begin
                  if (mi[k] == 3) begin
                     sv[k] = value;
                     sd[k] = dp;
                  end
                  mi[k] = (mi[k] + 1) % 4;
               end
               last[k] = g;
            end
         end
      end
      #1;
      chk("disp_b16", {an16, seg16, dpn16}, exp_disp(0));
      chk("disp_b0", {an0, seg0, dpn0}, exp_disp(1));
   endtask

   task automatic pulse_reset(input int n);
      rst_n = 1'b0;
      on = '{1'b0, 1'b0};
      pend.delete();
      rel = 0;
      #1;
      chk("async_rst_b16", {an16, seg16, dpn16}, 12'hFFF);
      chk("async_rst_b0", {an0, seg0, dpn0}, 12'hFFF);
      repeat (n) cyc();
      rst_n = 1'b1;
   endtask

   function automatic logic [15:0] rnd_val();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) begin
         v[4*i +: 4] = ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0;
      end
      return v;
   endfunction

   task automatic run(input int n, input int wmin, input int wmax, input int pchg);
      for (int i = 0; i < n; i++) begin
         if (left <= 0) begin
            clk_slow = ~clk_slow;
            left = $urandom_range(wmax, wmin);
         end
         left--;
         if (pchg != 0 && $urandom_range(pchg - 1, 0) == 0) begin
            value = rnd_val();
            dp = 4'($urandom);
         end
         if (pchg != 0 && $urandom_range(4 * pchg, 0) == 0) blank_lz = ~blank_lz;
         cyc();
      end
   endtask

   initial begin
      on = '{1'b0, 1'b0};
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) clk_slow = ~clk_slow;
         cyc();
      end

      // full-rate scan of 1234, then a mid-frame value change
      clk_slow = 1'b0;
      value = 16'h1234;
      dp = 4'b0100;
      blank_lz = 1'b0;
      rst_n = 1'b1;
      left = 2500;
      run(12000, 2500, 2500, 0);
      for (int i = 0; i < 6000 && mi[0] != 1; i++) run(1, 2500, 2500, 0);
      value = 16'hABCD;
      run(22000, 2500, 2500, 0);

      // reset while the third digit is lit
      for (int i = 0; i < 6000 && !(mi[0] == 2 && g - last[0] > 100); i++)
         run(1, 2500, 2500, 0);
      pulse_reset(3);
      clk_slow = 1'b0;
      left = 40;
      run(300, 30, 60, 0);

      // leading-zero handling
      value = 16'h0050;
      dp = 4'b0001;
      blank_lz = 1'b1;
      run(600, 30, 60, 0);
      value = 16'h0000;
      run(600, 30, 60, 0);
      blank_lz = 1'b0;
      run(600, 30, 60, 0);

      // random: short pulses, ticks inside blank gaps, random resets
      for (int r = 0; r < 30; r++) begin
         run($urandom_range(900, 300), 1, 40, 20);
         if ($urandom_range(2, 0) == 0) clk_slow = ~clk_slow;
         pulse_reset($urandom_range(4, 1));
         left = $urandom_range(6, 1);
      end
      run(500, 1, 40, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
